// File: rtl/vector_alu_sequencer_pkg.sv
// Shared encodings for the vector ALU sequencer.
// SEW codes, FSM states and geometry helpers.
package vector_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_RSV = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_FIN   = 2'b11
  } state_e;

  function automatic int words_of(
    input int vlen,
    input int width
  );
    return vlen / width;
  endfunction

  function automatic int vlmax8_of(input int vlen);
    return vlen / 8;
  endfunction

endpackage

// File: rtl/vector_byte_mask_gen.sv
// Per-word byte activity mask from element
// index, vl and the v0 mask register.
module vector_byte_mask_gen #(
  parameter int VLMAX8 = 16,
  parameter int AW     = 2,
  parameter int VLW    = 5
) (
  input  logic [AW-1:0]     word,
  input  logic [1:0]        sew,
  input  logic [VLW-1:0]    vl_eff,
  input  logic              vm,
  input  logic [VLMAX8-1:0] v0,
  output logic [3:0]        mask
);

  localparam int GW = AW + 2;

  function automatic logic byte_on(
    input logic [GW-1:0]     g,
    input logic [1:0]        s,
    input logic [VLW-1:0]    vl,
    input logic              m,
    input logic [VLMAX8-1:0] v
  );
    logic [GW-1:0] e;
    e = g >> s;
    return (VLW'(e) < vl) && (m || v[e]);
  endfunction

  always_comb begin
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[b] = byte_on({word, 2'(b)},
                        sew, vl_eff, vm, v0);
    end
  end

endmodule

// File: rtl/vector_alu_sequencer.sv
// Walks a vector register word by word through
// the packed add/sub ALU with masked writeback.
module vector_alu_sequencer
  import vector_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int VLEN  = 128,
  localparam int WORDS  = words_of(VLEN, WIDTH),
  localparam int VLMAX8 = vlmax8_of(VLEN),
  localparam int AW     = $clog2(WORDS),
  localparam int VLW    = $clog2(VLMAX8) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_sew,
  input  logic [VLW-1:0]    i_vl,
  input  logic              i_vm,
  input  logic              i_sub,
  input  logic [VLMAX8-1:0] i_v0,
  output logic              o_rd_en,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data1,
  input  logic [WIDTH-1:0]  i_rd_data2,
  output logic [WIDTH-1:0]  o_alu_in1,
  output logic [WIDTH-1:0]  o_alu_in2,
  output logic              o_alu_8bits,
  output logic              o_alu_16bits,
  output logic              o_alu_sub,
  output logic [3:0]        o_alu_masks,
  input  logic [WIDTH-1:0]  i_alu_result,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_wr_addr,
  output logic [WIDTH-1:0]  o_wr_data,
  output logic [3:0]        o_wr_be,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_e            state;
  logic [1:0]        sew_q;
  logic              vm_q;
  logic              sub_q;
  logic [VLMAX8-1:0] v0_q;
  logic [VLW-1:0]    vl_q;
  logic [AW-1:0]     last_q;
  logic              s1_valid;
  logic [AW-1:0]     s1_addr;
  logic [3:0]        rd_mask;

  logic [VLW-1:0]    vmax_c;
  logic [VLW-1:0]    vl_eff_c;
  logic [VLW+1:0]    bytes_c;
  logic [VLW+1:0]    nw_c;
  logic [AW-1:0]     last_c;
  logic              empty_c;
  logic              rsv_c;

  always_comb begin
    vmax_c   = VLW'(VLMAX8) >> i_sew;
    vl_eff_c = (i_vl < vmax_c) ? i_vl : vmax_c;
    bytes_c  = (VLW+2)'(vl_eff_c) << i_sew;
    nw_c     = (bytes_c + (VLW+2)'(3)) >> 2;
    last_c   = AW'(nw_c - (VLW+2)'(1));
    rsv_c    = (i_sew == SEW_RSV);
    empty_c  = rsv_c || (vl_eff_c == '0);
  end

  vector_byte_mask_gen #(
    .VLMAX8 (VLMAX8),
    .AW     (AW),
    .VLW    (VLW)
  ) u_mask (
    .word   (o_rd_addr),
    .sew    (sew_q),
    .vl_eff (vl_q),
    .vm     (vm_q),
    .v0     (v0_q),
    .mask   (rd_mask)
  );

  assign o_alu_in1 = s1_valid ? i_rd_data1 : '0;
  assign o_alu_in2 = s1_valid ? i_rd_data2 : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      sew_q        <= '0;
      vm_q         <= 1'b0;
      sub_q        <= 1'b0;
      v0_q         <= '0;
      vl_q         <= '0;
      last_q       <= '0;
      s1_valid     <= 1'b0;
      s1_addr      <= '0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_alu_8bits  <= 1'b0;
      o_alu_16bits <= 1'b0;
      o_alu_sub    <= 1'b0;
      o_alu_masks  <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_wr_be      <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      // operand stage: mask/controls line up with returning read data
      s1_valid     <= o_rd_en;
      s1_addr      <= o_rd_addr;
      o_alu_masks  <= o_rd_en ? rd_mask : '0;
      o_alu_8bits  <= o_rd_en && (sew_q == SEW_8);
      o_alu_16bits <= o_rd_en && (sew_q == SEW_16);
      o_alu_sub    <= o_rd_en && sub_q;
      o_wr_en      <= s1_valid;
      o_wr_addr    <= s1_valid ? s1_addr : '0;
      o_wr_data    <= s1_valid ? i_alu_result : '0;
      o_wr_be      <= s1_valid ? o_alu_masks : '0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            sew_q  <= i_sew;
            vm_q   <= i_vm;
            sub_q  <= i_sub;
            v0_q   <= i_v0;
            vl_q   <= vl_eff_c;
            last_q <= last_c;
            o_busy <= 1'b1;
            if (empty_c) begin
              state  <= S_FIN;
              o_done <= 1'b1;
              o_err  <= rsv_c;
            end else begin
              state     <= S_RUN;
              o_rd_en   <= 1'b1;
              o_rd_addr <= '0;
            end
          end
        end
        S_RUN: begin
          if (o_rd_addr == last_q) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            state     <= S_DRAIN;
          end else begin
            o_rd_addr <= o_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (o_wr_en && !s1_valid) begin
            state  <= S_FIN;
            o_done <= 1'b1;
          end
        end
        S_FIN: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer with
// a register-file and packed-ALU model.
module tb_vector_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sew;
  logic [4:0]  vl;
  logic        vm;
  logic        sub;
  logic [15:0] v0;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        a8;
  logic        a16;
  logic        asub;
  logic [3:0]  amask;
  logic [31:0] ares;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] m1 [4];
  logic [31:0] m2 [4];

  int n_checks = 0;
  int n_fail   = 0;

  int          n_wr, n_rd, done_cyc, err_cyc;
  int          rd_bad, busy_bad, wr_after_rst;
  int          wr_cyc [8];
  logic [1:0]  wr_a [8];
  logic [31:0] wr_d [8];
  logic [3:0]  wr_b [8];
  logic        rst_zero;

  always #5 clk = ~clk;

  vector_alu_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_sew        (sew),
    .i_vl         (vl),
    .i_vm         (vm),
    .i_sub        (sub),
    .i_v0         (v0),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data1   (rd1),
    .i_rd_data2   (rd2),
    .o_alu_in1    (in1),
    .o_alu_in2    (in2),
    .o_alu_8bits  (a8),
    .o_alu_16bits (a16),
    .o_alu_sub    (asub),
    .o_alu_masks  (amask),
    .i_alu_result (ares),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_wr_be      (wr_be),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rd1 <= m1[rd_addr];
      rd2 <= m2[rd_addr];
    end else begin
      rd1 <= '0;
      rd2 <= '0;
    end
  end

  always_comb begin
    ares = '0;
    if (a8) begin
      for (int i = 0; i < 4; i++)
        ares[8*i +: 8] = asub ?
          in1[8*i +: 8] - in2[8*i +: 8] :
          in1[8*i +: 8] + in2[8*i +: 8];
    end else if (a16) begin
      for (int i = 0; i < 2; i++)
        ares[16*i +: 16] = asub ?
          in1[16*i +: 16] - in2[16*i +: 16] :
          in1[16*i +: 16] + in2[16*i +: 16];
    end else begin
      ares = asub ? in1 - in2 : in1 + in2;
    end
    for (int i = 0; i < 4; i++)
      if (!amask[i]) ares[8*i +: 8] = 8'h00;
  end

  function automatic logic [55:0] all_out();
    return {rd_en, rd_addr, in1, a8, a16, asub,
            amask, wr_en, wr_addr, wr_be,
            busy, done, err};
  endfunction

  task automatic run_op(
    input logic [1:0]  s,
    input logic [4:0]  l,
    input logic        m,
    input logic        sb,
    input logic [15:0] v,
    input int          extra,
    input int          rst_at
  );
    logic rdone;
    int   rcyc;
    rdone = 1'b0;
    rcyc  = 0;
    n_wr = 0; n_rd = 0; done_cyc = -1; err_cyc = -1;
    rd_bad = 0; busy_bad = 0; wr_after_rst = 0;
    rst_zero = 1'b0;
    sew = s; vl = l; vm = m; sub = sb; v0 = v;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (rd_en) begin
        if (rd_addr !== 2'(n_rd)) rd_bad++;
        n_rd++;
      end
      if (wr_en) begin
        if (n_wr < 8) begin
          wr_cyc[n_wr] = c;
          wr_a[n_wr] = wr_addr;
          wr_d[n_wr] = wr_data;
          wr_b[n_wr] = wr_be;
        end
        n_wr++;
        if (rdone) wr_after_rst++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (err) err_cyc = c;
      if (rst_at == 0) begin
        if (busy !== (done_cyc < 0 || c == done_cyc))
          busy_bad++;
      end
      if (rdone && c == rcyc + 1) begin
        rst = 1'b0;
        rst_zero = (all_out() == '0);
      end
      if (rst_at > 0 && !rdone && n_wr == rst_at) begin
        rst = 1'b1;
        rdone = 1'b1;
        rcyc = c;
      end
      start = (c == extra);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (all_out() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               all_out());
    end
  endtask

  task automatic test_add8();
    for (int i = 0; i < 4; i++) begin
      m1[i] = 32'h0102_0304;
      m2[i] = 32'h0101_0101;
    end
    run_op(2'b00, 5'd16, 1'b1, 1'b0, '0, 0, 0);
    n_checks++;
    if (n_wr !== 4 || n_rd !== 4 || rd_bad !== 0) begin
      n_fail++;
      $display("FAIL add8_counts: wr=%0d rd=%0d bad=%0d want 4 4 0",
               n_wr, n_rd, rd_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_cyc[i] !== 3 + i || wr_a[i] !== 2'(i) ||
          wr_d[i] !== 32'h0203_0405 || wr_b[i] !== 4'hF) begin
        n_fail++;
        $display("FAIL add8_wr%0d: cyc=%0d a=%0d d=%h be=%b want %0d %0d 02030405 1111",
                 i, wr_cyc[i], wr_a[i], wr_d[i], wr_b[i], 3 + i, i);
      end
    end
    n_checks++;
    if (done_cyc !== 7 || err_cyc !== -1 || busy_bad !== 0) begin
      n_fail++;
      $display("FAIL add8_done: done=%0d err=%0d busybad=%0d want 7 -1 0",
               done_cyc, err_cyc, busy_bad);
    end
  endtask

  task automatic test_sub16();
    for (int i = 0; i < 4; i++) begin
      m1[i] = 32'h0005_0005;
      m2[i] = 32'h0001_0002;
    end
    run_op(2'b01, 5'd3, 1'b1, 1'b1, '0, 0, 0);
    n_checks++;
    if (n_wr !== 2 || done_cyc !== 5) begin
      n_fail++;
      $display("FAIL sub16_counts: wr=%0d done=%0d want 2 5",
               n_wr, done_cyc);
    end
    n_checks++;
    if (wr_d[0] !== 32'h0004_0003 || wr_b[0] !== 4'b1111) begin
      n_fail++;
      $display("FAIL sub16_w0: d=%h be=%b want 00040003 1111",
               wr_d[0], wr_b[0]);
    end
    n_checks++;
    if (wr_a[1] !== 2'd1 || wr_b[1] !== 4'b0011 ||
        wr_d[1] !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL sub16_w1: a=%0d d=%h be=%b want 1 00000003 0011",
               wr_a[1], wr_d[1], wr_b[1]);
    end
  endtask

  task automatic test_masked();
    for (int i = 0; i < 4; i++) begin
      m1[i] = 32'h0102_0304;
      m2[i] = 32'h0101_0101;
    end
    run_op(2'b00, 5'd8, 1'b0, 1'b0, 16'h00A5, 0, 0);
    n_checks++;
    if (n_wr !== 2 || done_cyc !== 5) begin
      n_fail++;
      $display("FAIL mask_counts: wr=%0d done=%0d want 2 5",
               n_wr, done_cyc);
    end
    n_checks++;
    if (wr_b[0] !== 4'b0101 || wr_d[0] !== 32'h0003_0005) begin
      n_fail++;
      $display("FAIL mask_w0: be=%b d=%h want 0101 00030005",
               wr_b[0], wr_d[0]);
    end
    n_checks++;
    if (wr_b[1] !== 4'b1010 || wr_d[1] !== 32'h0200_0400) begin
      n_fail++;
      $display("FAIL mask_w1: be=%b d=%h want 1010 02000400",
               wr_b[1], wr_d[1]);
    end
  endtask

  task automatic test_empty();
    run_op(2'b00, 5'd0, 1'b1, 1'b0, '0, 0, 0);
    n_checks++;
    if (n_rd !== 0 || n_wr !== 0 || done_cyc !== 1 ||
        err_cyc !== -1 || busy_bad !== 0) begin
      n_fail++;
      $display("FAIL vl0: rd=%0d wr=%0d done=%0d err=%0d bb=%0d want 0 0 1 -1 0",
               n_rd, n_wr, done_cyc, err_cyc, busy_bad);
    end
    run_op(2'b11, 5'd16, 1'b1, 1'b0, '0, 0, 0);
    n_checks++;
    if (n_rd !== 0 || n_wr !== 0 || done_cyc !== 1 ||
        err_cyc !== 1) begin
      n_fail++;
      $display("FAIL sew_rsv: rd=%0d wr=%0d done=%0d err=%0d want 0 0 1 1",
               n_rd, n_wr, done_cyc, err_cyc);
    end
  endtask

  task automatic test_clamp32();
    for (int i = 0; i < 4; i++) begin
      m1[i] = 32'h1000_0000 + 32'(i);
      m2[i] = 32'h0000_0001;
    end
    run_op(2'b10, 5'd9, 1'b1, 1'b0, '0, 2, 0);
    n_checks++;
    if (n_wr !== 4 || n_rd !== 4 || done_cyc !== 7 ||
        busy_bad !== 0) begin
      n_fail++;
      $display("FAIL clamp32_counts: wr=%0d rd=%0d done=%0d bb=%0d want 4 4 7 0",
               n_wr, n_rd, done_cyc, busy_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_a[i] !== 2'(i) || wr_b[i] !== 4'hF ||
          wr_d[i] !== 32'h1000_0001 + 32'(i)) begin
        n_fail++;
        $display("FAIL clamp32_wr%0d: a=%0d d=%h be=%b want %0d %h 1111",
                 i, wr_a[i], wr_d[i], wr_b[i], i,
                 32'h1000_0001 + 32'(i));
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) begin
      m1[i] = 32'h0102_0304;
      m2[i] = 32'h0101_0101;
    end
    run_op(2'b00, 5'd16, 1'b1, 1'b0, '0, 0, 2);
    n_checks++;
    if (n_wr !== 2 || wr_after_rst !== 0 ||
        done_cyc !== -1) begin
      n_fail++;
      $display("FAIL midrst_writes: wr=%0d after=%0d done=%0d want 2 0 -1",
               n_wr, wr_after_rst, done_cyc);
    end
    n_checks++;
    if (rst_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_zero: got %b want 1", rst_zero);
    end
    run_op(2'b00, 5'd16, 1'b1, 1'b0, '0, 0, 0);
    n_checks++;
    if (n_wr !== 4 || done_cyc !== 7 ||
        wr_d[3] !== 32'h0203_0405) begin
      n_fail++;
      $display("FAIL midrst_restart: wr=%0d done=%0d d3=%h want 4 7 02030405",
               n_wr, done_cyc, wr_d[3]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    sew = '0; vl = '0; vm = 1'b1; sub = 1'b0; v0 = '0;
    for (int i = 0; i < 4; i++) begin
      m1[i] = '0;
      m2[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_add8();
    test_sub16();
    test_masked();
    test_empty();
    test_clamp32();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

Drives the packed add/sub vector ALU across a full vector register. On a start command it walks the register word by word: it issues register-file reads, presents operands, lane-width controls and per-byte masks to the ALU, and writes the masked results back with byte enables. It sits between the VPU instruction decode (start/config) and the vector register file/ALU pair, and produces the byte masks and lane controls that the ALU consumes.

## Interface
- `WIDTH`, 32: datapath word width in bits (4 byte lanes; only 32 is supported).
- `VLEN`, 128: vector register length in bits; `WORDS = VLEN/WIDTH`, `VLMAX8 = VLEN/8`.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start command; accepted only in IDLE.
- `i_sew`  in  2  element width: 00=8, 01=16, 10=32, 11=reserved.
- `i_vl`  in  $clog2(VLMAX8)+1  element count.
- `i_vm`  in  1  1=unmasked, 0=use `i_v0`.
- `i_sub`  in  1  0=add, 1=subtract (vs1 − vs2).
- `i_v0`  in  VLMAX8  mask bit per element index.
- `o_rd_en`, `o_rd_addr`  out  1, $clog2(WORDS)  read request/word index. Data returns the next cycle.
- `i_rd_data1`, `i_rd_data2`  in  WIDTH  vs1/vs2 words.
- `o_alu_in1`, `o_alu_in2`  out  WIDTH  ALU operands.
- `o_alu_8bits`, `o_alu_16bits`, `o_alu_sub`  out  1  ALU lane/operation controls.
- `o_alu_masks`  out  4  ALU byte masks.
- `i_alu_result`  in  WIDTH  masked ALU result.
- `o_wr_en`, `o_wr_addr`, `o_wr_data`, `o_wr_be`  out  1, $clog2(WORDS), WIDTH, 4  vd write port.
- `o_busy`, `o_done`, `o_err`  out  1  status. `o_done` and `o_err` are single-cycle pulses.

## Operation
- States:
  - IDLE: `i_start` goes to RUN, or to FIN if `i_vl==0` or `i_sew==11`.
  - RUN: one read per cycle; goes to DRAIN after word N−1 is issued.
  - DRAIN: waits until the last write is issued, then goes to FIN.
  - FIN: pulses `o_done`, returns to IDLE.
- Config is latched at the start. `vl_eff = min(i_vl, VLMAX8 >> sew)`. `N = ceil((vl_eff << sew) / 4)`.
- Byte mask generation for word w, byte b:
  - Global byte index `g = 4w+b`; element index `e = g >> sew`.
  - Byte is active iff `e < vl_eff` and (`vm` or `v0[e]`).
  - The active set gives both `o_alu_masks` and `o_wr_be`.
- Inactive bytes are never written: tail and masked-off bytes stay undisturbed.
- `o_alu_8bits = (sew==00)`, `o_alu_16bits = (sew==01)`, `o_alu_sub = latched sub`.
- `o_alu_in1/2` pass `i_rd_data1/2` through combinationally. Mask and control are pipelined to match.
- Reserved SEW (11): no reads or writes; `o_err` and `o_done` pulse together.
- `i_start` outside IDLE is ignored.
- `i_rst` at any time: state returns to IDLE and all outputs go to 0. No further writes occur.

## Timing
- Cycle 0 is the cycle in which `i_start` is high in IDLE.
- Reads: `o_rd_en`=1 in cycles 1..N with `o_rd_addr`=0..N−1.
- ALU operands are valid in cycles 2..N+1.
- Writes are registered: `o_wr_en` is high in cycles 3..N+2, with `o_wr_addr`=0..N−1. Throughput is one word per cycle.
- `o_done` is high in cycle N+3. For `vl_eff==0` or reserved SEW, `o_done` is high in cycle 1.
- `o_busy` is high from cycle 1 through the `o_done` cycle.
- A new `i_start` is accepted in the cycle after `o_done`.
- Reset values: all outputs 0, state IDLE.

## Structure
- Shared package/defines: SEW encodings, state encodings, `WORDS`/`VLMAX8` derivation.
- One sub-module, `vector_byte_mask_gen` (combinational): inputs word index, sew, vl_eff, vm, v0; output 4-bit byte mask.

## Test plan
1. sew=8, vl=16, vm=1, add, all words vs1=0x01020304, vs2=0x01010101 → 4 writes in cycles 3–6, data 0x02030405, be=1111, done in cycle 7.
2. sew=16, vl=3, sub, vs1=0x00050005, vs2=0x00010002 → 2 writes. Word0 data 0x00040003 be=1111; word1 be=0011.
3. sew=8, vl=8, vm=0, v0=0x00A5 → 2 writes, word0 be=0101, word1 be=1010.
4. vl=0, then sew=11 → each case: no `o_rd_en`/`o_wr_en`, done in cycle 1; `o_err`=1 only for sew=11.
5. sew=32, vl=9 → clamped to 4 writes. A second `i_start` in cycle 2 is ignored.
6. `i_rst` after 2 writes → no further `o_wr_en`, all outputs 0. A subsequent start completes normally.
